// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, control-state
// enum, datapath select encodings and the control-word payload.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'h13;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'h33;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_PC  = 4'd12,
        S_TRAP     = 4'd13
    } ctrl_state_t;

    typedef enum logic [SEL_W-1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [SEL_W-1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [SEL_W-1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALU     = 2'b10
    } result_src_t;

    typedef enum logic [SEL_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [SEL_W-1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Per-cycle control word driven onto the shared datapath.
    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        result_src_t result_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        logic        illegal_instr;
    } ctrl_t;

    // Immediate format implied by the opcode; I-format for anything else.
    function automatic imm_src_t imm_src_of(input logic [OPCODE_W-1:0] op);
        imm_src_t imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Control-output table: maps the current FSM state plus the two gating
// inputs (mem_ready, branch_taken) to the datapath control word.
// Ports:
//   state_i        current control state
//   mem_ready_i    memory completes the request this cycle
//   branch_taken_i beq comparison result
//   ctrl_c_o       combinational control word
module mc_ctrl_outputs
    import riscv_pkg::*;
(
    input  ctrl_state_t state_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output ctrl_t       ctrl_c_o
);

    always_comb begin
        ctrl_c_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_c_o.mem_req    = 1'b1;
                ctrl_c_o.adr_src    = 1'b0;
                // PC+4 is written back only once the instruction word arrives.
                ctrl_c_o.ir_write   = mem_ready_i;
                ctrl_c_o.pc_write   = mem_ready_i;
                ctrl_c_o.alu_src_a  = SRCA_PC;
                ctrl_c_o.alu_src_b  = SRCB_FOUR;
                ctrl_c_o.alu_op     = ALUOP_ADD;
                ctrl_c_o.result_src = RES_ALU;
            end
            S_DECODE: begin
                // Branch/jal target precomputed into ALUOut.
                ctrl_c_o.alu_src_a = SRCA_OLDPC;
                ctrl_c_o.alu_src_b = SRCB_IMM;
                ctrl_c_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_c_o.alu_src_a = SRCA_RS1;
                ctrl_c_o.alu_src_b = SRCB_IMM;
                ctrl_c_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_c_o.mem_req = 1'b1;
                ctrl_c_o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c_o.result_src = RES_MEMDATA;
                ctrl_c_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_c_o.mem_req   = 1'b1;
                ctrl_c_o.mem_write = 1'b1;
                ctrl_c_o.adr_src   = 1'b1;
            end
            S_EXECR: begin
                ctrl_c_o.alu_src_a = SRCA_RS1;
                ctrl_c_o.alu_src_b = SRCB_RS2;
                ctrl_c_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_c_o.alu_src_a = SRCA_RS1;
                ctrl_c_o.alu_src_b = SRCB_IMM;
                ctrl_c_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c_o.result_src = RES_ALUOUT;
                ctrl_c_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_c_o.alu_src_a  = SRCA_RS1;
                ctrl_c_o.alu_src_b  = SRCB_RS2;
                ctrl_c_o.alu_op     = ALUOP_SUB;
                ctrl_c_o.result_src = RES_ALUOUT;
                ctrl_c_o.pc_write   = branch_taken_i;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link.
                ctrl_c_o.result_src = RES_ALUOUT;
                ctrl_c_o.pc_write   = 1'b1;
                ctrl_c_o.alu_src_a  = SRCA_OLDPC;
                ctrl_c_o.alu_src_b  = SRCB_FOUR;
                ctrl_c_o.alu_op     = ALUOP_ADD;
            end
            S_JALR: begin
                ctrl_c_o.alu_src_a = SRCA_RS1;
                ctrl_c_o.alu_src_b = SRCB_IMM;
                ctrl_c_o.alu_op    = ALUOP_ADD;
            end
            S_JALR_PC: begin
                ctrl_c_o.result_src = RES_ALUOUT;
                ctrl_c_o.pc_write   = 1'b1;
                ctrl_c_o.alu_src_a  = SRCA_OLDPC;
                ctrl_c_o.alu_src_b  = SRCB_FOUR;
                ctrl_c_o.alu_op     = ALUOP_ADD;
            end
            S_TRAP: begin
                ctrl_c_o.illegal_instr = 1'b1;
            end
            default: begin
                ctrl_c_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core. Holds the state register and
// next-state logic; the per-state control word comes from mc_ctrl_outputs.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   op              opcode of the instruction register
//   branch_taken    beq comparison result
//   mem_ready       memory completes the current request
//   mem_req/mem_write/adr_src   memory port controls
//   ir_write/pc_write/reg_write architectural write enables
//   result_src/alu_src_a/alu_src_b/alu_op_type  datapath selects
//   immsrc          immediate format, follows op
//   illegal_instr   sticky unsupported-opcode flag
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] op,
    input  logic                branch_taken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    alu_op_type,
    output logic [SEL_W-1:0]    immsrc,
    output logic                illegal_instr
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_t       ctrl_c;
    ctrl_t       ctrl_out_c;
    imm_src_t    imm_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALR_PC;
            S_JALR_PC:  state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outputs u_outputs (
        .state_i        (state_q),
        .mem_ready_i    (mem_ready),
        .branch_taken_i (branch_taken),
        .ctrl_c_o       (ctrl_c)
    );

    // Everything is forced low while reset is held, even before the first
    // reset edge has put the state register into FETCH.
    assign ctrl_out_c = rst_n ? ctrl_c : '0;
    assign imm_c      = rst_n ? imm_src_of(op) : IMM_I;

    assign mem_req       = ctrl_out_c.mem_req;
    assign mem_write     = ctrl_out_c.mem_write;
    assign adr_src       = ctrl_out_c.adr_src;
    assign ir_write      = ctrl_out_c.ir_write;
    assign pc_write      = ctrl_out_c.pc_write;
    assign reg_write     = ctrl_out_c.reg_write;
    assign result_src    = ctrl_out_c.result_src;
    assign alu_src_a     = ctrl_out_c.alu_src_a;
    assign alu_src_b     = ctrl_out_c.alu_src_b;
    assign alu_op_type   = ctrl_out_c.alu_op;
    assign illegal_instr = ctrl_out_c.illegal_instr;
    assign immsrc        = imm_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instructions cycle by cycle
// and compares the full control vector against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op_type, immsrc;
    logic       illegal_instr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op_type   (alu_op_type),
        .immsrc        (immsrc),
        .illegal_instr (illegal_instr)
    );

    // Vector order: req wr adr ir pc rw res[2] a[2] b[2] aop[2] imm[2] ill
    function automatic logic [16:0] v(input logic req, input logic wr, input logic adr,
                                      input logic ir, input logic pc, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] aop,
                                      input logic [1:0] imm, input logic ill);
        return {req, wr, adr, ir, pc, rw, res, a, b, aop, imm, ill};
    endfunction

    // Sample mid-cycle, compare, then advance to just after the next edge.
    task automatic step(input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        #1;
        obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op_type, immsrc, illegal_instr};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        op           = 7'h03;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;

        step("reset_pre_edge", 17'h0);
        step("reset_held",     17'h0);
        rst_n = 1'b1;

        // lw, zero wait states: 5 cycles
        op = 7'h03; mem_ready = 1'b1;
        step("lw_fetch",   v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("lw_decode",  v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        step("lw_memadr",  v(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd0,0));
        step("lw_memread", v(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0));
        step("lw_memwb",   v(0,0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,2'd0,0));

        // sw with one fetch wait and three store wait cycles
        op = 7'h23; mem_ready = 1'b0;
        step("sw_fetch_wait", v(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd1,0));
        mem_ready = 1'b1;
        step("sw_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd1,0));
        step("sw_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd1,0));
        step("sw_memadr", v(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd1,0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("sw_memwrite_wait", v(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));
        end
        mem_ready = 1'b1;
        step("sw_memwrite_done", v(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));

        // beq taken
        op = 7'h63;
        step("beq1_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd2,0));
        step("beq1_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd2,0));
        branch_taken = 1'b1;
        step("beq_taken",   v(0,0,0,0,1,0,2'd0,2'd2,2'd0,2'd1,2'd2,0));
        // beq not taken
        branch_taken = 1'b0;
        step("beq0_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd2,0));
        step("beq0_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd2,0));
        step("beq_not_taken", v(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd1,2'd2,0));

        // jalr: 5 cycles
        op = 7'h67;
        step("jalr_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("jalr_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        step("jalr_exec",   v(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd0,0));
        step("jalr_pc",     v(0,0,0,0,1,0,2'd0,2'd1,2'd2,2'd0,2'd0,0));
        step("jalr_aluwb",  v(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));

        // R-type
        op = 7'h33;
        step("r_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("r_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        step("r_exec",   v(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
        step("r_aluwb",  v(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));

        // I-type
        op = 7'h13;
        step("i_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("i_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        step("i_exec",   v(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd2,2'd0,0));
        step("i_aluwb",  v(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));

        // jal
        op = 7'h6F;
        step("jal_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd3,0));
        step("jal_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd3,0));
        step("jal_exec",   v(0,0,0,0,1,0,2'd0,2'd1,2'd2,2'd0,2'd3,0));
        step("jal_aluwb",  v(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd3,0));

        // Illegal opcode: TRAP is sticky and ignores mem_ready
        op = 7'h7F;
        step("trap_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("trap_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i % 2 == 0);
            step("trap_hold", v(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,1));
        end
        rst_n = 1'b0; mem_ready = 1'b1;
        step("trap_reset", 17'h0);
        rst_n = 1'b1; op = 7'h23; mem_ready = 1'b0;
        step("post_trap_fetch", v(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd1,0));

        // Reset during MEMWRITE aborts the store
        mem_ready = 1'b1;
        step("abort_fetch",  v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd1,0));
        step("abort_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd1,0));
        step("abort_memadr", v(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd1,0));
        mem_ready = 1'b0;
        step("abort_memwrite", v(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));
        rst_n = 1'b0;
        step("abort_reset", 17'h0);
        rst_n = 1'b1; op = 7'h33;
        step("abort_refetch_wait", v(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        mem_ready = 1'b1;
        step("abort_refetch", v(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
        step("abort_r_decode", v(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0,0));
        step("abort_r_exec",   v(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
